// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, per-channel debounce
// and single-cycle press/release events. Optional auto-repeat under BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int          NUM_BTNS        = 4,
    parameter logic [28:0] DEBOUNCE_CYCLES = 29'd1000000,
    parameter logic [28:0] REPEAT_DELAY    = 29'd50000000,
    parameter logic [28:0] REPEAT_PERIOD   = 29'd10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 29'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 29'd1);

    logic [NUM_BTNS-1:0] sync1_r;
    logic [NUM_BTNS-1:0] sync2_r;
    logic [NUM_BTNS-1:0] accept_s;
    logic [NUM_BTNS-1:0] rptFire_s;
    logic [CNT_W-1:0]    debCnt_r     [NUM_BTNS];
    logic [CNT_W-1:0]    debCntNext_s [NUM_BTNS];

    // Zero-valued timing parameters leave this marker block in the elaborated hierarchy
    if (DEBOUNCE_CYCLES == 29'd0 || REPEAT_DELAY == 29'd0 || REPEAT_PERIOD == 29'd0) begin : gParamBelowMinimum
    end

    // Per-channel debounce: count differing samples, accept at DEBOUNCE_CYCLES-1
    always_comb begin
        accept_s = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            debCntNext_s[i] = '0;
            if (sync2_r[i] == btn_level[i]) begin
                debCntNext_s[i] = '0;
            end else if (debCnt_r[i] == CNT_MAX) begin
                accept_s[i]     = 1'b1;
                debCntNext_s[i] = '0;
            end else begin
                debCntNext_s[i] = debCnt_r[i] + CNT_W'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [28:0]      RPT_TOP    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W      = $clog2(RPT_TOP + 29'd1);
    localparam logic [RPT_W-1:0] DELAY_MAX  = RPT_W'(REPEAT_DELAY - 29'd1);
    localparam logic [RPT_W-1:0] PERIOD_MAX = RPT_W'(REPEAT_PERIOD - 29'd1);

    logic [RPT_W-1:0]    rptCnt_r     [NUM_BTNS];
    logic [RPT_W-1:0]    rptCntNext_s [NUM_BTNS];
    logic [NUM_BTNS-1:0] rptPhase_r;
    logic [NUM_BTNS-1:0] rptPhaseNext_s;

    // Repeat timing: phase 0 waits REPEAT_DELAY, phase 1 fires every REPEAT_PERIOD
    always_comb begin
        rptFire_s      = '0;
        rptPhaseNext_s = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            rptCntNext_s[i] = '0;
            if (accept_s[i] || !btn_level[i]) begin
                rptCntNext_s[i]   = '0;
                rptPhaseNext_s[i] = 1'b0;
            end else if (rptCnt_r[i] == (rptPhase_r[i] ? PERIOD_MAX : DELAY_MAX)) begin
                rptFire_s[i]      = 1'b1;
                rptCntNext_s[i]   = '0;
                rptPhaseNext_s[i] = 1'b1;
            end else begin
                rptCntNext_s[i]   = rptCnt_r[i] + RPT_W'(1);
                rptPhaseNext_s[i] = rptPhase_r[i];
            end
        end
    end

    // Repeat counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            rptPhase_r <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                rptCnt_r[i] <= '0;
            end
        end else begin
            rptPhase_r <= rptPhaseNext_s;
            for (int i = 0; i < NUM_BTNS; i++) begin
                rptCnt_r[i] <= rptCntNext_s[i];
            end
        end
    end
`else
    assign rptFire_s = '0;
`endif

    // Synchronizer, debounce counters, debounced level and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r     <= '0;
            sync2_r     <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                debCnt_r[i] <= '0;
            end
        end else begin
            sync1_r     <= btn_raw;
            sync2_r     <= sync1_r;
            btn_level   <= btn_level ^ accept_s;
            btn_press   <= (accept_s & ~btn_level) | rptFire_s;
            btn_release <= accept_s & btn_level;
            for (int i = 0; i < NUM_BTNS; i++) begin
                debCnt_r[i] <= debCntNext_s[i];
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3; repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int nVec;
    int nErr;

    btn_conditioner #(
        .NUM_BTNS       (4),
        .DEBOUNCE_CYCLES(29'd4),
        .REPEAT_DELAY   (29'd10),
        .REPEAT_PERIOD  (29'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        btn_raw = 4'h0;
        tick();
        tick();
        tick();
        nVec++;
        if ({btn_level, btn_press, btn_release} !== 12'h000) begin
            nErr++;
            $display("FAIL reset: lvl/press/rel got %h/%h/%h want 0/0/0", btn_level, btn_press, btn_release);
        end
        rst = 1'b0;
        tick();
        nVec++;
        if ({btn_level, btn_press, btn_release} !== 12'h000) begin
            nErr++;
            $display("FAIL reset_idle: lvl/press/rel got %h/%h/%h want 0/0/0", btn_level, btn_press, btn_release);
        end
    endtask

    task automatic test_press;
        logic [3:0] eL, eP;
        btn_raw = 4'h1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            eL = (t >= 6) ? 4'h1 : 4'h0;
            eP = (t == 6) ? 4'h1 : 4'h0;
            nVec++;
            if ({btn_level, btn_press, btn_release} !== {eL, eP, 4'h0}) begin
                nErr++;
                $display("FAIL press t=%0d: lvl/press/rel got %h/%h/%h want %h/%h/0", t, btn_level, btn_press, btn_release, eL, eP);
            end
        end
    endtask

    task automatic test_release;
        logic [3:0] eL, eR;
        btn_raw = 4'h0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            eL = (t >= 6) ? 4'h0 : 4'h1;
            eR = (t == 6) ? 4'h1 : 4'h0;
            nVec++;
            if ({btn_level, btn_press, btn_release} !== {eL, 4'h0, eR}) begin
                nErr++;
                $display("FAIL release t=%0d: lvl/press/rel got %h/%h/%h want %h/0/%h", t, btn_level, btn_press, btn_release, eL, eR);
            end
        end
    endtask

    task automatic test_bounce;
        logic [13:0] pattern;
        pattern = 14'b00000001110111;
        for (int t = 0; t < 14; t++) begin
            btn_raw = {2'b00, pattern[t], 1'b0};
            tick();
            nVec++;
            if ({btn_level, btn_press, btn_release} !== 12'h000) begin
                nErr++;
                $display("FAIL bounce t=%0d: lvl/press/rel got %h/%h/%h want 0/0/0", t, btn_level, btn_press, btn_release);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] eL, eP, eR;
        btn_raw = 4'hC;
        for (int t = 1; t <= 7; t++) begin
            tick();
            eL = (t >= 6) ? 4'hC : 4'h0;
            eP = (t == 6) ? 4'hC : 4'h0;
            nVec++;
            if ({btn_level, btn_press, btn_release} !== {eL, eP, 4'h0}) begin
                nErr++;
                $display("FAIL simul_press t=%0d: lvl/press/rel got %h/%h/%h want %h/%h/0", t, btn_level, btn_press, btn_release, eL, eP);
            end
        end
        btn_raw = 4'h0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            eL = (t >= 6) ? 4'h0 : 4'hC;
            eR = (t == 6) ? 4'hC : 4'h0;
            nVec++;
            if ({btn_level, btn_press, btn_release} !== {eL, 4'h0, eR}) begin
                nErr++;
                $display("FAIL simul_release t=%0d: lvl/press/rel got %h/%h/%h want %h/0/%h", t, btn_level, btn_press, btn_release, eL, eR);
            end
        end
    endtask

    task automatic test_reset_midcount;
        logic [3:0] eL, eP;
        btn_raw = 4'h1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            nVec++;
            if ({btn_level, btn_press, btn_release} !== 12'h000) begin
                nErr++;
                $display("FAIL midcount_pre t=%0d: lvl/press/rel got %h/%h/%h want 0/0/0", t, btn_level, btn_press, btn_release);
            end
        end
        rst = 1'b1;
        tick();
        nVec++;
        if ({btn_level, btn_press, btn_release} !== 12'h000) begin
            nErr++;
            $display("FAIL midcount_rst: lvl/press/rel got %h/%h/%h want 0/0/0", btn_level, btn_press, btn_release);
        end
        rst = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            eL = (t == 6) ? 4'h1 : 4'h0;
            eP = (t == 6) ? 4'h1 : 4'h0;
            nVec++;
            if ({btn_level, btn_press, btn_release} !== {eL, eP, 4'h0}) begin
                nErr++;
                $display("FAIL midcount_post t=%0d: lvl/press/rel got %h/%h/%h want %h/%h/0", t, btn_level, btn_press, btn_release, eL, eP);
            end
        end
    endtask

    // Entered on the cycle right after the press pulse; t counts cycles from that pulse.
    task automatic test_autorepeat;
        logic [3:0] eL, eP, eR;
        for (int t = 1; t <= 30; t++) begin
            tick();
            eL = (t >= 25) ? 4'h0 : 4'h1;
            eR = (t == 25) ? 4'h1 : 4'h0;
`ifdef BTN_AUTOREPEAT_EN
            eP = (t == 10 || t == 13 || t == 16 || t == 19 || t == 22) ? 4'h1 : 4'h0;
`else
            eP = 4'h0;
`endif
            nVec++;
            if ({btn_level, btn_press, btn_release} !== {eL, eP, eR}) begin
                nErr++;
                $display("FAIL autorepeat t=%0d: lvl/press/rel got %h/%h/%h want %h/%h/%h", t, btn_level, btn_press, btn_release, eL, eP, eR);
            end
            if (t == 19) begin
                btn_raw = 4'h0;
            end
        end
    endtask

    initial begin
        nVec    = 0;
        nErr    = 0;
        rst     = 1'b1;
        btn_raw = 4'h0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_autorepeat();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
